uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter PAYLOAD_BITS, default 8: byte width of stored and transmitted data.
REQ-002 Parameter DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2 entries (16).
REQ-003 Parameter BUSY_TIMEOUT, default 4: cycles to wait for uart_tx_busy after a launch.
REQ-004 Single clock and reset (decided): clk; reset is synchronous and active-low, port resetn.
REQ-005 clk  in  1  system clock; all state updates on rising edge.
REQ-006 resetn  in  1  synchronous active-low reset.
REQ-007 wr_en  in  1  push strobe, one byte per high cycle.
REQ-008 wr_data  in  PAYLOAD_BITS  byte to push.
REQ-009 full  out  1  high when level == 2**DEPTH_LOG2.
REQ-010 empty  out  1  high when level == 0.
REQ-011 level  out  DEPTH_LOG2+1  current occupancy.
REQ-012 overflow  out  1  sticky, set when a push is dropped.
REQ-013 uart_tx_busy  in  1  transmitter busy, from UART_TX.
REQ-014 uart_tx_en  out  1  one-cycle launch strobe to UART_TX.
REQ-015 uart_tx_data  out  PAYLOAD_BITS  byte to UART_TX, registered.

Function
REQ-016 Push: wr_en high and full low at an edge SHALL write wr_data at the write pointer, advance it, and increment level.
REQ-017 Push while full SHALL be dropped: no storage change, overflow set to 1 and held until reset; full is sampled before any same-cycle pop.
REQ-018 Pointers SHALL wrap modulo 2**DEPTH_LOG2; full and empty SHALL derive from level only.
REQ-019 Simultaneous accepted push and pop SHALL leave level unchanged.
REQ-020 Drain FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE: if empty is low and uart_tx_busy is low, load uart_tx_data from the head entry, pop (advance the read pointer, decrement level), and go to LAUNCH; otherwise stay.
REQ-022 LAUNCH: uart_tx_en SHALL be 1 for exactly this one cycle; next state WAIT_BUSY and clear the timeout counter.
REQ-023 WAIT_BUSY: uart_tx_busy high goes to WAIT_DONE; otherwise increment the counter, and when it reaches BUSY_TIMEOUT-1 go to IDLE (the byte is considered sent).
REQ-024 WAIT_DONE: stay until uart_tx_busy is low, then go to IDLE.
REQ-025 uart_tx_data SHALL remain stable from the LAUNCH cycle until the FSM re-enters IDLE.
REQ-026 uart_tx_en SHALL be 0 in every state other than LAUNCH.
REQ-027 Latency: with the FIFO empty, FSM in IDLE and busy low, a push at edge N SHALL make uart_tx_en high in the cycle after edge N+1.
REQ-028 Bytes SHALL be launched in push order; no byte is launched twice or skipped, except dropped overflow pushes.

Reset
REQ-029 With resetn low at an edge: pointers 0, level 0, empty 1, full 0, overflow 0, FSM IDLE, uart_tx_en 0, uart_tx_data 0, timeout counter 0.
REQ-030 Reset mid-transfer SHALL discard all stored bytes and any in-flight launch; wr_en is ignored while resetn is low.
REQ-031 Storage array contents need no reset.

Structure
REQ-032 The FSM state encoding SHALL be localparams in shared package uart_pkg, together with the PAYLOAD_BITS default and the BIT_RATE/CLK_HZ defaults shared with UART_RX/UART_TX.
REQ-033 Storage and pointers SHALL be one sub-module, sync_fifo, parameterised by width and DEPTH_LOG2; the drain FSM lives in uart_tx_fifo.

Verification
REQ-034 Single byte: push 0xA5 into an idle empty FIFO, busy held low -> uart_tx_en high for exactly 1 cycle, 2 cycles after the push, with uart_tx_data=0xA5; empty back to 1.
REQ-035 Burst: push 0x01..0x05 back-to-back; the busy model goes high 1 cycle after en and stays high for 10 cycles -> five launches in order 0x01..0x05, each only after busy has fallen; level peaks at 5 or less.
REQ-036 Overflow: busy held high, push 17 bytes 0x00..0x10 -> full=1 at 16 entries, byte 0x10 dropped, overflow=1; after busy is released, 0x00..0x0F are sent in order.
REQ-037 Timeout: busy never rises after a launch of 0x3C -> FSM returns to IDLE 4 cycles after LAUNCH; the next byte launches normally.
REQ-038 Simultaneous push and pop at level 3 -> level stays 3; wrap: push and drain 40 bytes -> all 40 received in order.
REQ-039 Reset mid-operation: resetn low for 1 cycle during WAIT_DONE with 6 bytes queued -> level 0, uart_tx_en 0, overflow 0, and no further launches until new pushes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default parameters and the TX drain FSM encoding.
package uart_pkg;

    // Defaults shared by UART_RX, UART_TX and the TX FIFO.
    localparam int unsigned PAYLOAD_BITS_DEF = 8;
    localparam int unsigned BIT_RATE_DEF     = 115200;
    localparam int unsigned CLK_HZ_DEF       = 50_000_000;

    // Drain FSM state encoding.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        StIdle     = ST_IDLE,
        StLaunch   = ST_LAUNCH,
        StWaitBusy = ST_WAIT_BUSY,
        StWaitDone = ST_WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers, occupancy and sticky overflow.
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  overflow_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  push_ok, pop_ok;

    // Full/empty come from the level alone, so pointer wrap never aliases them.
    always_comb begin
        full_o      = (level_q == LEVEL_MAX);
        empty_o     = (level_q == '0);
        level_o     = level_q;
        overflow_o  = overflow_q;
        head_data_o = mem_q[rd_ptr_q];
        // Full is judged on the pre-edge level, so a push at full is dropped
        // even if a pop happens in the same cycle.
        push_ok     = push_i & ~full_o;
        pop_ok      = pop_i & ~empty_o;
    end

    // Next-state for pointers, level and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
            default: level_d = level_q;
        endcase
        if (push_i && full_o) begin
            overflow_d = 1'b1;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write; contents are don't-care after reset, only pointers matter.
    always_ff @(posedge clk) begin
        if (resetn && push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter, drained by a launch/handshake FSM.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wr_en,
    input  logic [PAYLOAD_BITS-1:0] wr_data,
    output logic                    full,
    output logic                    empty,
    output logic [DEPTH_LOG2:0]     level,
    output logic                    overflow,
    input  logic                    uart_tx_busy,
    output logic                    uart_tx_en,
    output logic [PAYLOAD_BITS-1:0] uart_tx_data
);

    localparam int unsigned CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    tx_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic [PAYLOAD_BITS-1:0] head_data;
    logic                    pop;

    sync_fifo #(
        .WIDTH      (PAYLOAD_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (wr_en),
        .push_data_i (wr_data),
        .pop_i       (pop),
        .head_data_o (head_data),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level),
        .overflow_o  (overflow)
    );

    // Drain FSM: pop the head when the transmitter is free, strobe it out, then
    // wait for busy to rise and fall (or give up waiting for it to rise).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        pop        = 1'b0;
        uart_tx_en = 1'b0;
        cnt_inc    = cnt_q + CNT_W'(1);
        unique case (state_q)
            StIdle: begin
                if (!empty && !uart_tx_busy) begin
                    data_d  = head_data;
                    pop     = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                uart_tx_en = 1'b1;
                cnt_d      = '0;
                state_d    = StWaitBusy;
            end
            StWaitBusy: begin
                if (uart_tx_busy) begin
                    state_d = StWaitDone;
                end else begin
                    cnt_d = cnt_inc;
                    // No busy response in time: treat the byte as sent.
                    if (cnt_inc >= CNT_LAST) begin
                        state_d = StIdle;
                    end
                end
            end
            StWaitDone: begin
                if (!uart_tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, timeout counter and output data register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Data only reloads on a pop, so it holds from launch until back in idle.
    always_comb begin
        uart_tx_data = data_q;
    end

endmodule
